iob_fifo_rd_stream: RTL and testbench

IOB_FIFO_RD_STREAM -- requirements
Module: iob_fifo_rd_stream

---
 rtl/iob_fifo_rd_stream_pkg.sv | 19 +
 rtl/iob_skid_buf2.sv | 53 +++++
 rtl/iob_fifo_rd_stream.sv | 98 +++++++++
 tb/tb_iob_fifo_rd_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_rd_stream_pkg.sv
// iob_fifo_rd_stream_pkg: constants and helpers shared by the FIFO read-stream
// adapter and its two-entry skid buffer.
package iob_fifo_rd_stream_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int LEVEL_W   = 2;
    localparam int BEAT_W    = 16;

    typedef logic [LEVEL_W-1:0] level_t;

    // True when a new FIFO read still fits in the local buffer. This counts the
    // words held locally, plus the word already in flight, minus the word leaving this cycle.
    function automatic logic may_request(input level_t cnt, input logic pend, input logic pop);
        logic [LEVEL_W:0] sum;
        sum = {1'b0, cnt} + {{LEVEL_W{1'b0}}, pend} - {{LEVEL_W{1'b0}}, pop};
        return sum < (LEVEL_W+1)'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/iob_skid_buf2.sv
// iob_skid_buf2: two-entry in-order buffer with head/tail pointers and an
// occupancy count. Push and pop may happen in the same cycle.
module iob_skid_buf2
    import iob_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output level_t            count_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    level_t            cnt_q, cnt_d;

    // Next pointers and count; simultaneous push and pop leave the count unchanged
    always_comb begin
        head_d = head_q ^ pop_i;
        tail_d = tail_q ^ push_i;
        cnt_d  = cnt_q + level_t'(push_i) - level_t'(pop_i);
    end

    // Storage and pointer registers, cleared by the synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            cnt_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (push_i) begin
                mem_q[tail_q] <= data_i;
            end
        end
    end

    // The head entry is always the oldest word held
    always_comb begin
        data_o  = mem_q[head_q];
        count_o = cnt_q;
    end

endmodule

// File: rtl/iob_fifo_rd_stream.sv
// iob_fifo_rd_stream: turns a FIFO read port with one-cycle read latency into a
// valid/ready stream, buffering up to two words locally so the stream never stalls
// on the FIFO latency. Packet framing on m_last is built only when the macro
// IOB_FIFO_RD_STREAM_LAST_EN is defined; otherwise m_last is tied low.
module iob_fifo_rd_stream
    import iob_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        level
);

    if (PKT_LEN < 1 || PKT_LEN > 65535) begin : gBadPktLen
        $error("iob_fifo_rd_stream: PKT_LEN must lie in 1..65535");
    end

    level_t            bufCount;
    logic [DATA_W-1:0] bufHead;
    logic              bufValid;
    logic              popEn;
    logic              rdEn;
    logic              pend_q, pend_d;

    // Read request: only ask the FIFO when the word it returns is guaranteed a slot
    always_comb begin
        bufValid = ~rst & (bufCount != '0);
        popEn    = bufValid & m_ready;
        rdEn     = ~rst & ~fifo_empty & may_request(bufCount, pend_q, popEn);
        pend_d   = rdEn;
    end

    // pend marks the cycle in which the FIFO presents the word requested last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    iob_skid_buf2 #(
        .DATA_W (DATA_W)
    ) uBuf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (pend_q),
        .pop_i   (popEn),
        .data_i  (fifo_data),
        .data_o  (bufHead),
        .count_o (bufCount)
    );

    // Stream outputs come straight from the buffer registers and are forced quiet during reset
    always_comb begin
        fifo_read_en = rdEn;
        m_valid      = bufValid;
        m_data       = rst ? '0 : bufHead;
        level        = rst ? '0 : bufCount;
    end

`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;

    // Beat counter advances on every accepted word and wraps after the last beat of a packet
    always_comb begin
        beat_d = beat_q;
        if (popEn) begin
            beat_d = (beat_q == LastBeat) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    // Beat counter register, restarting packets from beat 0 on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_last = bufValid & (beat_q == LastBeat);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_iob_fifo_rd_stream.sv
// tb_iob_fifo_rd_stream: directed bench for iob_fifo_rd_stream with a behavioural
// FIFO (one-cycle read latency). Built with or without IOB_FIFO_RD_STREAM_LAST_EN.
module tb_iob_fifo_rd_stream;

    localparam int DW = 8;
    localparam int PL = 4;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    localparam bit LAST_ON = 1'b1;
`else
    localparam bit LAST_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    level;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] outQ[$];
    logic          lastQ[$];
    int            popCyc[$];
    logic          holdEmpty;
    logic          pendPrev;
    logic          sValid, sLast, sRd;
    logic [DW-1:0] sData;
    logic [1:0]    sLevel;
    int            maxOcc, maxLevel, rdEmptyCnt, rdCnt, lastIdle, cyc;

    always #5 clk = ~clk;

    iob_fifo_rd_stream #(
        .DATA_W  (DW),
        .PKT_LEN (PL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .level        (level)
    );

    // One clock: sample outputs at negedge, then model the FIFO read just after posedge
    task automatic tick();
        int occ;
        @(negedge clk);
        sValid = m_valid;
        sData  = m_data;
        sLast  = m_last;
        sLevel = level;
        sRd    = fifo_read_en;
        if (!rst) begin
            occ = int'(sLevel) + int'(pendPrev);
            if (occ > maxOcc) maxOcc = occ;
            if (int'(sLevel) > maxLevel) maxLevel = int'(sLevel);
            if (sRd && fifo_empty) rdEmptyCnt++;
            if (sLast && !sValid) lastIdle++;
            if (sValid && m_ready) begin
                outQ.push_back(sData);
                lastQ.push_back(sLast);
                popCyc.push_back(cyc);
            end
        end
        if (sRd) rdCnt++;
        @(posedge clk);
        #1;
        pendPrev = rst ? 1'b0 : sRd;
        if (sRd && fifoQ.size() > 0) fifo_data = fifoQ.pop_front();
        fifo_empty = holdEmpty || (fifoQ.size() == 0);
        cyc++;
    endtask

    task automatic clearRecords();
        outQ.delete();
        lastQ.delete();
        popCyc.delete();
        maxOcc = 0; maxLevel = 0; rdEmptyCnt = 0; rdCnt = 0; lastIdle = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        m_ready = 1'b0;
        holdEmpty = 1'b0;
        fifoQ.delete();
        fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clearRecords();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b1;
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h22);
        fifo_empty = 1'b0;
        tick();
        tick();
        total++; if (sValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", sValid); end
        total++; if (sData !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", sData); end
        total++; if (sLast !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%b want=0", sLast); end
        total++; if (sLevel !== 2'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", sLevel); end
        total++; if (sRd !== 1'b0) begin bad++; $display("[TB] FAIL reset_rden got=%b want=0", sRd); end
        fifoQ.delete();
        fifo_empty = 1'b1;
        rst = 1'b0;
        tick();
        total++; if (sValid !== 1'b0 || sLevel !== 2'd0) begin bad++; $display("[TB] FAIL reset_release got valid=%b level=%0d want valid=0 level=0", sValid, sLevel); end
    endtask

    task automatic test_single();
        logic          vAt [6];
        logic [DW-1:0] dAt [6];
        doReset();
        m_ready = 1'b1;
        fifoQ.push_back(8'hA5);
        fifo_empty = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vAt[i] = sValid;
            dAt[i] = sData;
        end
        for (int i = 0; i < 6; i++) begin
            logic want;
            want = (i == 2);
            total++; if (vAt[i] !== want) begin bad++; $display("[TB] FAIL single_valid cyc=%0d got=%b want=%b", i, vAt[i], want); end
        end
        total++; if (dAt[2] !== 8'hA5) begin bad++; $display("[TB] FAIL single_data got=%h want=a5", dAt[2]); end
        total++; if (rdCnt != 1) begin bad++; $display("[TB] FAIL single_rdpulses got=%0d want=1", rdCnt); end
    endtask

    task automatic test_stream();
        int guard;
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifoQ.push_back(8'(i));
        fifo_empty = 1'b0;
        guard = 0;
        while (outQ.size() < 16 && guard < 60) begin tick(); guard++; end
        total++; if (outQ.size() != 16) begin bad++; $display("[TB] FAIL stream_count got=%0d want=16", outQ.size()); end
        for (int i = 0; i < outQ.size(); i++) begin
            total++; if (outQ[i] !== 8'(i)) begin bad++; $display("[TB] FAIL stream_word idx=%0d got=%h want=%h", i, outQ[i], 8'(i)); end
        end
        if (popCyc.size() == 16) begin
            total++; if (popCyc[15] - popCyc[0] != 15) begin bad++; $display("[TB] FAIL stream_bubbles span got=%0d want=15", popCyc[15] - popCyc[0]); end
        end
        total++; if (maxLevel > 2) begin bad++; $display("[TB] FAIL stream_level max got=%0d want<=2", maxLevel); end
        total++; if (maxOcc > 2) begin bad++; $display("[TB] FAIL stream_occupancy max got=%0d want<=2", maxOcc); end
    endtask

    task automatic test_backpressure();
        int guard;
        int rdStall;
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifoQ.push_back(8'h20 + 8'(i));
        fifo_empty = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (outQ.size() != 2) begin bad++; $display("[TB] FAIL bp_prestall got=%0d want=2", outQ.size()); end
        m_ready = 1'b0;
        rdStall = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sRd) rdStall++;
            total++; if (sValid !== 1'b1 || sData !== 8'h22) begin bad++; $display("[TB] FAIL bp_hold cyc=%0d got valid=%b data=%h want valid=1 data=22", i, sValid, sData); end
        end
        total++; if (rdStall != 0) begin bad++; $display("[TB] FAIL bp_rden_stall got=%0d want=0", rdStall); end
        total++; if (sLevel !== 2'd2) begin bad++; $display("[TB] FAIL bp_level got=%0d want=2", sLevel); end
        m_ready = 1'b1;
        guard = 0;
        while (outQ.size() < 16 && guard < 60) begin tick(); guard++; end
        total++; if (outQ.size() != 16) begin bad++; $display("[TB] FAIL bp_count got=%0d want=16", outQ.size()); end
        for (int i = 0; i < outQ.size(); i++) begin
            total++; if (outQ[i] !== 8'h20 + 8'(i)) begin bad++; $display("[TB] FAIL bp_word idx=%0d got=%h want=%h", i, outQ[i], 8'h20 + 8'(i)); end
        end
        total++; if (maxOcc > 2) begin bad++; $display("[TB] FAIL bp_occupancy max got=%0d want<=2", maxOcc); end
    endtask

    task automatic test_last();
        int guard;
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) fifoQ.push_back(8'h40 + 8'(i));
        fifo_empty = 1'b0;
        guard = 0;
        while (outQ.size() < 12 && guard < 60) begin tick(); guard++; end
        total++; if (lastQ.size() != 12) begin bad++; $display("[TB] FAIL last_count got=%0d want=12", lastQ.size()); end
        for (int k = 0; k < lastQ.size(); k++) begin
            logic want;
            want = LAST_ON && ((k % PL) == PL - 1);
            total++; if (lastQ[k] !== want) begin bad++; $display("[TB] FAIL last_beat idx=%0d got=%b want=%b", k, lastQ[k], want); end
        end
        total++; if (lastIdle != 0) begin bad++; $display("[TB] FAIL last_idle got=%0d want=0", lastIdle); end
    endtask

    task automatic test_reset_mid();
        int guard;
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifoQ.push_back(8'h60 + 8'(i));
        fifo_empty = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        m_ready = 1'b0;
        tick();
        tick();
        total++; if (sLevel !== 2'd2) begin bad++; $display("[TB] FAIL rstmid_fill got=%0d want=2", sLevel); end
        m_ready = 1'b1;
        tick();
        total++; if (sRd !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_inflight got=%b want=1", sRd); end
        rst = 1'b1;
        m_ready = 1'b0;
        fifoQ.delete();
        fifo_empty = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++; if (sValid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b want=0", sValid); end
        total++; if (sLevel !== 2'd0) begin bad++; $display("[TB] FAIL rstmid_level got=%0d want=0", sLevel); end
        clearRecords();
        for (int i = 0; i < 4; i++) fifoQ.push_back(8'h55 + 8'(i));
        fifo_empty = 1'b0;
        m_ready = 1'b1;
        guard = 0;
        while (outQ.size() < 4 && guard < 30) begin tick(); guard++; end
        total++; if (outQ.size() != 4) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=4", outQ.size()); end
        if (outQ.size() == 4) begin
            total++; if (outQ[0] !== 8'h55) begin bad++; $display("[TB] FAIL rstmid_first got=%h want=55", outQ[0]); end
            for (int k = 0; k < 4; k++) begin
                logic want;
                want = LAST_ON && (k == 3);
                total++; if (lastQ[k] !== want) begin bad++; $display("[TB] FAIL rstmid_last idx=%0d got=%b want=%b", k, lastQ[k], want); end
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] expQ[$];
        int guard, seqErr, lastErr, n;
        doReset();
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] w;
            w = 8'($urandom_range(0, 255));
            fifoQ.push_back(w);
            expQ.push_back(w);
        end
        guard = 0;
        while (outQ.size() < 1000 && guard < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            holdEmpty = ($urandom_range(0, 3) == 0);
            fifo_empty = holdEmpty || (fifoQ.size() == 0);
            tick();
            guard++;
        end
        holdEmpty = 1'b0;
        total++; if (outQ.size() != 1000) begin bad++; $display("[TB] FAIL rand_count got=%0d want=1000", outQ.size()); end
        seqErr = 0;
        lastErr = 0;
        n = (outQ.size() < 1000) ? outQ.size() : 1000;
        for (int k = 0; k < n; k++) begin
            if (outQ[k] !== expQ[k]) seqErr++;
            if (lastQ[k] !== (LAST_ON && ((k % PL) == PL - 1))) lastErr++;
        end
        total++; if (seqErr != 0) begin bad++; $display("[TB] FAIL rand_sequence wrong_words got=%0d want=0", seqErr); end
        total++; if (lastErr != 0) begin bad++; $display("[TB] FAIL rand_last wrong_flags got=%0d want=0", lastErr); end
        total++; if (maxOcc > 2) begin bad++; $display("[TB] FAIL rand_occupancy max got=%0d want<=2", maxOcc); end
        total++; if (rdEmptyCnt != 0) begin bad++; $display("[TB] FAIL rand_read_empty got=%0d want=0", rdEmptyCnt); end
    endtask

    // Test sequence
    initial begin
        rst = 1'b1;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_data = '0;
        holdEmpty = 1'b0;
        pendPrev = 1'b0;
        cyc = 0;
        clearRecords();
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_last();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
